// File: rtl/core_types_pkg.sv
// Shared core types: free-list and checkpoint sizing, tag/pointer/column types.
package core_types_pkg;

  localparam int NUM_PHYS_REGS          = 64;
  localparam int NUM_ARCH_REGS          = 32;
  localparam int PHYS_TAG_W             = $clog2(NUM_PHYS_REGS);
  localparam int FREE_LIST_DEPTH        = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int LOG_FREE_LIST_DEPTH    = $clog2(FREE_LIST_DEPTH);
  localparam int CHECKPOINT_COLUMNS     = 4;
  localparam int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS);

  typedef logic [PHYS_TAG_W-1:0]             phys_reg_tag_t;
  typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
  // Index plus one wrap bit, so full and empty are distinguishable.
  typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;

  // True when n is a positive power of two; used for elaboration checks.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/checkpoint_column_alloc.sv
// Round-robin checkpoint column allocator with clear and restore-range invalidate.
// A restore releases the restored column and every younger one, i.e. the
// circular range [restore_column, alloc_ptr-1]; the column count must be 2^n.
module checkpoint_column_alloc
  import core_types_pkg::*;
#(
  parameter int COLUMNS = CHECKPOINT_COLUMNS,
  parameter int COL_W   = $clog2(COLUMNS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               save_req_i,
  input  logic               clear_req_i,
  input  logic [COL_W-1:0]   clear_column_i,
  input  logic               restore_req_i,
  input  logic [COL_W-1:0]   restore_column_i,
  output logic               save_ready_o,
  output logic [COL_W-1:0]   save_column_o,
  output logic               save_taken_o,
  output logic               restore_taken_o,
  output logic [COLUMNS-1:0] col_valid_o
);

  logic [COLUMNS-1:0] col_valid_q, col_valid_d;
  logic [COLUMNS-1:0] restore_mask;
  logic [COL_W-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [COL_W-1:0]   span;

  function automatic logic [COL_W-1:0] col_offset(input logic [COL_W-1:0] a,
                                                  input logic [COL_W-1:0] b);
    return a - b;
  endfunction

  // Handshakes and the set of columns a restore would invalidate.
  always_comb begin
    restore_taken_o = restore_req_i & col_valid_q[restore_column_i];
    save_ready_o    = ~col_valid_q[alloc_ptr_q];
    save_column_o   = alloc_ptr_q;
    save_taken_o    = save_req_i & save_ready_o & ~restore_taken_o;
    col_valid_o     = col_valid_q;
    // A zero span means restore_column == alloc_ptr: every column is younger.
    span            = col_offset(alloc_ptr_q, restore_column_i);
    for (int c = 0; c < COLUMNS; c++) begin
      restore_mask[c] = (span == '0) ||
                        (col_offset(COL_W'(c), restore_column_i) < span);
    end
  end

  // Next state, applied in rising priority: clear, then save, then restore.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    col_valid_d = col_valid_q;
    alloc_ptr_d = alloc_ptr_q;
    if (clear_req_i) col_valid_d[clear_column_i] = 1'b0;
    if (save_taken_o) begin
      col_valid_d[alloc_ptr_q] = 1'b1;
      alloc_ptr_d              = alloc_ptr_q + 1'b1;
    end
    if (restore_taken_o) begin
      col_valid_d = col_valid_d & ~restore_mask;
      alloc_ptr_d = restore_column_i;
    end
  end

  // Column state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_valid_q <= '0;
      alloc_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      col_valid_q <= col_valid_d;
      alloc_ptr_q <= alloc_ptr_d;
    end
  end

endmodule

// File: rtl/phys_reg_free_list_ckpt.sv
// Physical-register free list with branch checkpoint save/restore of the head.
// Dispatch pops at the head, commit pushes at the tail; a mispredict rewinds
// the head to a saved value so speculatively allocated tags become free again.
module phys_reg_free_list_ckpt #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int NUM_ARCH_REGS      = 32,
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int DEPTH              = NUM_PHYS_REGS - NUM_ARCH_REGS,
  parameter int TAG_W              = $clog2(NUM_PHYS_REGS),
  parameter int PTR_W              = $clog2(DEPTH) + 1,
  parameter int COL_W              = $clog2(CHECKPOINT_COLUMNS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dequeue_req,
  output logic             dequeue_valid,
  output logic [TAG_W-1:0] dequeue_tag,
  input  logic             enqueue_valid,
  input  logic [TAG_W-1:0] enqueue_tag,
  input  logic             save_req,
  output logic             save_ready,
  output logic [COL_W-1:0] save_column,
  input  logic             restore_req,
  input  logic [COL_W-1:0] restore_column,
  input  logic             clear_req,
  input  logic [COL_W-1:0] clear_column,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             overflow_err
);

  import core_types_pkg::*;

  localparam int IDX_W = PTR_W - 1;

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("phys_reg_free_list_ckpt: DEPTH must be a power of 2");
  end
  if (!is_pow2(CHECKPOINT_COLUMNS)) begin : g_cols_chk
    $error("phys_reg_free_list_ckpt: CHECKPOINT_COLUMNS must be a power of 2");
  end

  logic [TAG_W-1:0] fl_mem_q     [DEPTH];
  logic [PTR_W-1:0] saved_head_q [CHECKPOINT_COLUMNS];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             overflow_q;
  logic             save_taken, restore_taken, deq_fire, enq_fire;
  logic [CHECKPOINT_COLUMNS-1:0] col_valid;

  checkpoint_column_alloc #(
    .COLUMNS (CHECKPOINT_COLUMNS),
    .COL_W   (COL_W)
  ) u_col_alloc (
    .clk_i            (CLK),
    .rst_i            (RST),
    .save_req_i       (save_req),
    .clear_req_i      (clear_req),
    .clear_column_i   (clear_column),
    .restore_req_i    (restore_req),
    .restore_column_i (restore_column),
    .save_ready_o     (save_ready),
    .save_column_o    (save_column),
    .save_taken_o     (save_taken),
    .restore_taken_o  (restore_taken),
    .col_valid_o      (col_valid)
  );

  // Status, head tag and next pointers; a restore overrides this cycle's dequeue.
  always_comb begin
    count         = tail_q - head_q;
    full          = (count == PTR_W'(DEPTH));
    dequeue_valid = (head_q != tail_q);
    dequeue_tag   = fl_mem_q[head_q[IDX_W-1:0]];
    overflow_err  = overflow_q;
    deq_fire      = dequeue_req & dequeue_valid & ~restore_taken;
    enq_fire      = enqueue_valid & ~full;
    head_d        = head_q;
    if (restore_taken) head_d = saved_head_q[restore_column];
    else if (deq_fire) head_d = head_q + 1'b1;
    tail_d        = tail_q + PTR_W'(enq_fire);
  end

  // Tag storage: reset loads the tags not bound to architectural registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) fl_mem_q[i] <= TAG_W'(NUM_ARCH_REGS + i);
    end else if (enq_fire) begin
      fl_mem_q[tail_q[IDX_W-1:0]] <= enqueue_tag;
    end
  end

  // Head/tail pointers and sticky overflow flag; tail starts one lap ahead.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= PTR_W'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_q | (enqueue_valid & full);
    end
  end

  // Saved heads capture the post-dequeue head of the saving cycle.
  // NOTE: no reset here; a slot is only read once its col_valid bit is set.
  always_ff @(posedge CLK) begin
    if (save_taken) saved_head_q[save_column] <= head_d;
  end

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Self-checking bench: expected head tags are queued as bursts are planned and
// popped as the DUT presents each tag for dequeue.
module tb_phys_reg_free_list_ckpt;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       dequeue_req = 1'b0;
  logic       dequeue_valid;
  logic [5:0] dequeue_tag;
  logic       enqueue_valid = 1'b0;
  logic [5:0] enqueue_tag = '0;
  logic       save_req = 1'b0;
  logic       save_ready;
  logic [1:0] save_column;
  logic       restore_req = 1'b0;
  logic [1:0] restore_column = '0;
  logic       clear_req = 1'b0;
  logic [1:0] clear_column = '0;
  logic [5:0] count;
  logic       full;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  phys_reg_free_list_ckpt dut (
    .CLK            (CLK),
    .RST            (RST),
    .dequeue_req    (dequeue_req),
    .dequeue_valid  (dequeue_valid),
    .dequeue_tag    (dequeue_tag),
    .enqueue_valid  (enqueue_valid),
    .enqueue_tag    (enqueue_tag),
    .save_req       (save_req),
    .save_ready     (save_ready),
    .save_column    (save_column),
    .restore_req    (restore_req),
    .restore_column (restore_column),
    .clear_req      (clear_req),
    .clear_column   (clear_column),
    .count          (count),
    .full           (full),
    .overflow_err   (overflow_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later, drop all single-cycle requests.
  task automatic tick();
    @(posedge CLK);
    #1;
    dequeue_req   = 1'b0;
    enqueue_valid = 1'b0;
    save_req      = 1'b0;
    restore_req   = 1'b0;
    clear_req     = 1'b0;
  endtask

  // Dequeue one tag; the head tag is compared against the scoreboard front.
  task automatic deq_one(input string tag);
    dequeue_req = 1'b1;
    check({tag, "_valid"}, dequeue_valid, 1);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check(tag, dequeue_tag, exp_q.pop_front());
    tick();
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) deq_one(tag);
  endtask

  task automatic enq(input int t);
    enqueue_valid = 1'b1;
    enqueue_tag   = 6'(t);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Reset state.
    check("rst_valid", dequeue_valid, 1);
    check("rst_tag", dequeue_tag, 32);
    check("rst_count", count, 32);
    check("rst_full", full, 1);
    check("rst_save_ready", save_ready, 1);
    check("rst_save_col", save_column, 0);
    check("rst_ovf", overflow_err, 0);

    // Three dequeues: 32, 33, 34.
    for (int i = 0; i < 3; i++) exp_q.push_back(32 + i);
    deq_one("deq_a");
    check("full_drop", full, 0);
    check("count_31", count, 31);
    drain("deq_a");
    check("count_29", count, 29);

    // Save column 0, dequeue 35..38, restore column 0.
    check("save_col0", save_column, 0);
    save_req = 1'b1;
    tick();
    check("save_col_next", save_column, 1);
    check("col_valid_0001", dut.col_valid, 4'b0001);
    for (int i = 0; i < 4; i++) exp_q.push_back(35 + i);
    drain("deq_b");
    check("count_25", count, 25);
    restore_req    = 1'b1;
    restore_column = 2'd0;
    tick();
    check("rest_tag", dequeue_tag, 35);
    check("rest_count", count, 29);
    check("rest_alloc", save_column, 0);
    check("rest_cols", dut.col_valid, 4'b0000);

    // Exhaust all columns, then clears.
    for (int i = 0; i < 4; i++) begin
      save_req = 1'b1;
      tick();
    end
    check("all_cols", dut.col_valid, 4'b1111);
    check("all_not_ready", save_ready, 0);
    save_req = 1'b1;
    tick();
    check("ign_cols", dut.col_valid, 4'b1111);
    check("ign_alloc", save_column, 0);
    clear_req = 1'b1; clear_column = 2'd2;
    tick();
    check("clr2_cols", dut.col_valid, 4'b1011);
    save_req = 1'b1;
    tick();
    check("clr2_not_ready", save_ready, 0);
    check("clr2_cols_hold", dut.col_valid, 4'b1011);
    clear_req = 1'b1; clear_column = 2'd0;
    tick();
    check("clr0_ready", save_ready, 1);
    check("clr0_col", save_column, 0);
    clear_req = 1'b1; clear_column = 2'd1;
    tick();
    clear_req = 1'b1; clear_column = 2'd3;
    tick();
    check("clr_all", dut.col_valid, 4'b0000);

    // Saves with dequeues to cols 0,1,2 (saved heads 4,5,6); restore col 1.
    for (int i = 0; i < 3; i++) exp_q.push_back(35 + i);
    for (int i = 0; i < 3; i++) begin
      save_req = 1'b1;
      deq_one("deq_c");
    end
    check("c_cols", dut.col_valid, 4'b0111);
    restore_req = 1'b1; restore_column = 2'd1;
    tick();
    check("c_rest_cols", dut.col_valid, 4'b0001);
    check("c_rest_alloc", save_column, 1);
    check("c_rest_tag", dequeue_tag, 37);
    check("c_rest_count", count, 27);

    // Restore col 0 + enqueue 5 + dequeue in one cycle.
    restore_req = 1'b1; restore_column = 2'd0;
    enqueue_valid = 1'b1; enqueue_tag = 6'd5;
    dequeue_req = 1'b1;
    tick();
    check("d_tag", dequeue_tag, 36);
    check("d_count", count, 29);
    check("d_cols", dut.col_valid, 4'b0000);
    check("d_alloc", save_column, 0);

    // Fill, overflow with tag 7, then drain the whole wrapped ring.
    enq(8); enq(9); enq(10);
    check("e_full", full, 1);
    check("e_count", count, 32);
    check("e_ovf_clear", overflow_err, 0);
    enq(7);
    check("e_ovf", overflow_err, 1);
    check("e_ovf_count", count, 32);
    tick(); tick();
    check("e_ovf_sticky", overflow_err, 1);
    for (int i = 36; i < 64; i++) exp_q.push_back(i);
    exp_q.push_back(5); exp_q.push_back(8);
    exp_q.push_back(9); exp_q.push_back(10);
    drain("deq_e");
    check("e_empty_valid", dequeue_valid, 0);
    check("e_empty_count", count, 0);

    // Dequeue while empty ignored; enqueue not bypassed.
    dequeue_req = 1'b1;
    enqueue_valid = 1'b1; enqueue_tag = 6'd12;
    check("nb_valid", dequeue_valid, 0);
    tick();
    check("nb_valid_next", dequeue_valid, 1);
    check("nb_tag", dequeue_tag, 12);
    check("nb_count", count, 1);

    // Reset asserted mid-burst.
    enq(20); enq(21);
    dequeue_req = 1'b1;
    tick();
    dequeue_req = 1'b1;
    #2 RST = 1'b1;
    #1;
    check("mr_count", count, 32);
    check("mr_ovf", overflow_err, 0);
    check("mr_tag", dequeue_tag, 32);
    check("mr_full", full, 1);
    #2 RST = 1'b0;
    dequeue_req = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32 + i);
    drain("deq_f");
    check("f_count", count, 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list_ckpt.md
Name: phys_reg_free_list_ckpt

Overview:
- Parametrised physical-register free list with branch checkpoint save/restore for the OoO MIPS core.
- Dispatch dequeues a free phys reg tag for each renamed destination. Commit enqueues the freed safe (previous) mapping.
- BRU dispatch saves the head pointer into a checkpoint column. Mispredict restore rewinds the head, so speculatively allocated tags become free again.
- Successor to the fixed 32-entry list: depth, tag width and column count are all parametrised, and columns are tracked for age.

Parameters:
- NUM_PHYS_REGS, 64, total physical registers.
- NUM_ARCH_REGS, 32, architectural registers.
- CHECKPOINT_COLUMNS, 4, number of saved-head slots.
- DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS, list capacity. Must be a power of 2; an elaboration-time assertion enforces this.
- TAG_W, $clog2(NUM_PHYS_REGS), phys reg tag width.
- PTR_W, $clog2(DEPTH)+1, pointer width: index plus wrap bit.
- COL_W, $clog2(CHECKPOINT_COLUMNS), column index width.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- dequeue_req  in  1  dispatch takes head tag this cycle
- dequeue_valid  out  1  list non-empty, head tag valid
- dequeue_tag  out  TAG_W  tag at head (combinational from head)
- enqueue_valid  in  1  commit returns a tag
- enqueue_tag  in  TAG_W  freed tag
- save_req  in  1  allocate checkpoint
- save_ready  out  1  column at alloc_ptr is free
- save_column  out  COL_W  column that a save this cycle uses
- restore_req  in  1  mispredict rewind
- restore_column  in  COL_W  column to restore
- clear_req  in  1  branch resolved correct, release column
- clear_column  in  COL_W  column to release
- count  out  PTR_W  number of free tags (tail-head)
- full  out  1  count==DEPTH
- overflow_err  out  1  sticky: enqueue attempted while full

Behaviour:
- Storage:
  - DEPTH x TAG_W circular array.
  - head and tail pointers, PTR_W bits each.
  - Per column: saved_head (PTR_W) and col_valid.
  - alloc_ptr (COL_W), round-robin.
- Reset (asynchronous):
  - array[i] = NUM_ARCH_REGS+i, so default 32..63.
  - head = 0; tail = 0 with wrap bit set, so count = DEPTH.
  - All col_valid = 0; alloc_ptr = 0; overflow_err = 0.
  - Resulting outputs: dequeue_valid=1, dequeue_tag=32, full=1, save_ready=1, save_column=0.
- Dequeue:
  - If dequeue_req & dequeue_valid, head += 1 at the clock edge.
  - dequeue_req while empty is ignored. No bypass: a tag enqueued this cycle is visible next cycle.
- Enqueue:
  - If enqueue_valid & !full, write array[tail], tail += 1.
  - If enqueue_valid & full, drop the tag and set overflow_err.
  - Enqueue is accepted in every cycle, including restore cycles. The tail is never rewound.
- Save:
  - If save_req & save_ready: saved_head[alloc_ptr] = head after this cycle's dequeue.
  - Same cycle: col_valid[alloc_ptr] = 1, alloc_ptr += 1 (mod CHECKPOINT_COLUMNS).
  - save_req while !save_ready is ignored. Upstream stalls on save_ready.
- Clear: if clear_req, col_valid[clear_column] = 0. alloc_ptr is unchanged.
- Restore:
  - Taken if restore_req & col_valid[restore_column].
  - head = saved_head[restore_column].
  - Invalidate restore_column and every column circularly from restore_column up to alloc_ptr-1 (the younger checkpoints).
  - alloc_ptr = restore_column.
  - restore_req to an invalid column is a no-op.
- Priority within one cycle:
  - Restore overrides dequeue and save; both are ignored that cycle.
  - Clear and restore to the same column: restore wins.
  - Clear to a column being saved this cycle: save wins.
- Wrap: pointers wrap naturally at 2*DEPTH. Index = low bits. Empty when head==tail; full when the indices are equal and the wrap bits differ.
- Invariant: after restore, count = tail - saved_head <= DEPTH. Commit only returns tags that were dequeued.

Decomposition:
- Shared package core_types_pkg gains: FREE_LIST_DEPTH, LOG_FREE_LIST_DEPTH, CHECKPOINT_COLUMNS, checkpoint_column_t, phys_reg_tag_t, and a new free_list_ptr_t of width LOG_FREE_LIST_DEPTH+1.
- One natural sub-module: checkpoint_column_alloc. It holds the col_valid vector and alloc_ptr, and implements the save/clear/restore-range invalidate logic, reused later by the map table.

Test Plan:
- Reset then 3 dequeues -> tags 32, 33, 34 on consecutive cycles; count 32 -> 29; full drops after the first.
- Save at count=29 (save_column=0), then 4 dequeues (35..38), then restore column 0 -> next dequeue_tag=35, count=29, alloc_ptr=0, col_valid=0000.
- Save 4 columns with no clears -> save_ready=0 after the 4th. Save_req ignored. Clear col 2 then save -> still not ready (alloc_ptr=0 is valid). Clear col 0 -> save_ready=1, save_column=0.
- Saves to cols 0,1,2, then restore col 1 -> cols 1 and 2 invalid, col 0 valid, alloc_ptr=1.
- Same cycle: restore + enqueue tag 5 + dequeue_req -> head rewinds, tag 5 written at tail, dequeue ignored, count = tail+1 - saved_head.
- Full list + enqueue tag 7 -> tag dropped, overflow_err=1 and held. Assert RST mid-burst -> contents back to 32..63, overflow_err=0.
